sync_fifo_param: RTL and testbench

- Single-clock, parametrised successor to the fixed 8x64 clock-crossing fetch FIFO.
- Used on the AXI side of the fetch and memory path where producer and consumer share axi_clk, for example beat buffering ahead of a later crossing.
- Adds generic width and depth, an occupancy count, almost-full and almost-empty flags, synchronous flush, full-with-read pass-through, and sticky overflow/underflow error flags.
- Output is first-word-fall-through (FWFT): the head entry is always visible on rd_data_o.

---
 rtl/cpu_consts.sv | 9 +
 rtl/fifo_ram_sdp.sv | 27 ++
 rtl/sync_fifo_param.sv | 116 +++++++++++
 tb/tb_sync_fifo_param.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_consts.sv
// Shared fetch-path constants: default payload width and buffer depth.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_consts;

    localparam int FETCH_DATA_W = 64;
    localparam int FETCH_DEPTH  = 8;

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port storage array: one write port, one read port, no reset.
// Latency: write lands on the rising edge; read is combinational from the array.
// Backpressure: none; the caller guarantees a write only targets a free entry.
module fifo_ram_sdp #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage write; contents are deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock first-word-fall-through FIFO with occupancy count, almost flags and sticky errors.
// Latency: a write into an empty FIFO is visible on rd_data_o the next cycle; a pop advances the head next cycle.
// Backpressure: writes while full are dropped (overflow) unless a pop happens the same cycle.
module sync_fifo_param
    import cpu_consts::*;
#(
    parameter int DATA_W    = FETCH_DATA_W,
    parameter int DEPTH     = FETCH_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       axi_clk,
    input  logic                       axi_resetn,
    input  logic                       flush_i,
    input  logic                       wr_en_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    output logic                       wr_full_o,
    output logic                       wr_almost_full_o,
    input  logic                       rd_en_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       rd_empty_o,
    output logic                       rd_almost_empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic                       underflow_o,
    input  logic                       err_clr_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic is_empty, is_full;
    logic rd_accept, wr_ok, wr_accept;
    logic ovf_set, unf_set;

    // Full/empty come from the count register, never from pointer comparison
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);

    // Flush overrides both requests; a pop frees a slot for a same-cycle write
    assign rd_accept = rd_en_i & ~is_empty & ~flush_i;
    assign wr_ok     = wr_en_i & (~is_full | (rd_en_i & ~is_empty));
    assign wr_accept = wr_ok & ~flush_i;
    assign ovf_set   = wr_en_i & ~wr_ok & ~flush_i;
    assign unf_set   = rd_en_i & is_empty & ~flush_i;

    // Next-state for pointers, count and sticky error flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        // A set in the same cycle as a clear wins
        ovf_d = ovf_set | (ovf_q & ~err_clr_i);
        unf_d = unf_set | (unf_q & ~err_clr_i);
    end

    // State registers, cleared immediately on reset assertion
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_ram_sdp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i     (axi_clk),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data_i),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data_o)
    );

    assign wr_full_o         = is_full;
    assign wr_almost_full_o  = (count_q >= AF_C);
    assign rd_empty_o        = is_empty;
    assign rd_almost_empty_o = (count_q <= AE_C);
    assign count_o           = count_q;
    assign overflow_o        = ovf_q;
    assign underflow_o       = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at default parameters (64 x 8, AF=6, AE=2).
// Latency: inputs driven 1ns after a rising edge, outputs sampled after the next edge.
// Backpressure: exercised through fill, overflow and full-with-read steps.
module tb_sync_fifo_param;

    logic        axi_clk;
    logic        axi_resetn;
    logic        flush_i;
    logic        wr_en_i;
    logic [63:0] wr_data_i;
    logic        wr_full_o;
    logic        wr_almost_full_o;
    logic        rd_en_i;
    logic [63:0] rd_data_o;
    logic        rd_empty_o;
    logic        rd_almost_empty_o;
    logic [3:0]  count_o;
    logic        overflow_o;
    logic        underflow_o;
    logic        err_clr_i;

    int errors = 0;
    int checks = 0;

    sync_fifo_param dut (
        .axi_clk           (axi_clk),
        .axi_resetn        (axi_resetn),
        .flush_i           (flush_i),
        .wr_en_i           (wr_en_i),
        .wr_data_i         (wr_data_i),
        .wr_full_o         (wr_full_o),
        .wr_almost_full_o  (wr_almost_full_o),
        .rd_en_i           (rd_en_i),
        .rd_data_o         (rd_data_o),
        .rd_empty_o        (rd_empty_o),
        .rd_almost_empty_o (rd_almost_empty_o),
        .count_o           (count_o),
        .overflow_o        (overflow_o),
        .underflow_o       (underflow_o),
        .err_clr_i         (err_clr_i)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, 64'(count_o), 64'd0);
        chk({tag, "_empty"}, 64'(rd_empty_o), 64'd1);
        chk({tag, "_aempty"}, 64'(rd_almost_empty_o), 64'd1);
        chk({tag, "_full"}, 64'(wr_full_o), 64'd0);
        chk({tag, "_afull"}, 64'(wr_almost_full_o), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow_o), 64'd0);
        chk({tag, "_unf"}, 64'(underflow_o), 64'd0);
    endtask

    task automatic push(input logic [63:0] d);
        wr_en_i   = 1'b1;
        wr_data_i = d;
        step();
        wr_en_i   = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [63:0] exp);
        chk(tag, rd_data_o, exp);
        rd_en_i = 1'b1;
        step();
        rd_en_i = 1'b0;
    endtask

    initial begin
        logic [63:0] nw, nr;
        axi_resetn = 1'b0;
        flush_i    = 1'b0;
        wr_en_i    = 1'b0;
        wr_data_i  = '0;
        rd_en_i    = 1'b0;
        err_clr_i  = 1'b0;
        #3;
        chk_reset_vals("rst");
        step();
        axi_resetn = 1'b1;
        step();

        // 1: fill 1..8 then drain in order
        for (int i = 1; i <= 8; i++) begin
            push(64'(i));
            chk("t1_count", 64'(count_o), 64'(i));
            chk("t1_afull", 64'(wr_almost_full_o), 64'(i >= 6));
            chk("t1_full", 64'(wr_full_o), 64'(i == 8));
            chk("t1_aempty", 64'(rd_almost_empty_o), 64'(i <= 2));
        end
        for (int i = 1; i <= 8; i++) begin
            pop_chk("t1_data", 64'(i));
            chk("t1_dcount", 64'(count_o), 64'(8 - i));
        end
        chk("t1_empty", 64'(rd_empty_o), 64'd1);

        // 2: write while full is dropped and flagged; clear removes the flag
        for (int i = 1; i <= 8; i++) push(64'h10 + 64'(i));
        push(64'h99);
        chk("t2_ovf", 64'(overflow_o), 64'd1);
        chk("t2_count", 64'(count_o), 64'd8);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        chk("t2_clr", 64'(overflow_o), 64'd0);

        // 3: full with simultaneous write and pop: count holds, 0xAA lands last
        chk("t3_head0", rd_data_o, 64'h11);
        wr_en_i   = 1'b1;
        rd_en_i   = 1'b1;
        wr_data_i = 64'hAA;
        step();
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        chk("t3_count", 64'(count_o), 64'd8);
        chk("t3_ovf", 64'(overflow_o), 64'd0);
        for (int i = 2; i <= 8; i++) pop_chk("t3_data", 64'h10 + 64'(i));
        pop_chk("t3_last", 64'hAA);
        chk("t3_empty", 64'(rd_empty_o), 64'd1);

        // 4: empty with write and read: write accepted, read flagged
        wr_en_i   = 1'b1;
        rd_en_i   = 1'b1;
        wr_data_i = 64'h55;
        step();
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        chk("t4_count", 64'(count_o), 64'd1);
        chk("t4_data", rd_data_o, 64'h55);
        chk("t4_unf", 64'(underflow_o), 64'd1);
        chk("t4_empty", 64'(rd_empty_o), 64'd0);
        err_clr_i = 1'b1;
        pop_chk("t4_pop", 64'h55);
        err_clr_i = 1'b0;
        chk("t4_clr", 64'(underflow_o), 64'd0);
        chk("t4_empty2", 64'(rd_empty_o), 64'd1);

        // 5: steady state at count 3 across pointer wrap
        push(64'h30);
        push(64'h31);
        push(64'h32);
        nw = 64'h33;
        nr = 64'h30;
        for (int i = 0; i < 20; i++) begin
            chk("t5_data", rd_data_o, nr);
            wr_en_i   = 1'b1;
            rd_en_i   = 1'b1;
            wr_data_i = nw;
            step();
            nw++;
            nr++;
            chk("t5_count", 64'(count_o), 64'd3);
            chk("t5_aempty", 64'(rd_almost_empty_o), 64'd0);
        end
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pop_chk("t5_drain", nr);
            nr++;
        end
        chk("t5_empty", 64'(rd_empty_o), 64'd1);

        // 6: flush beats a same-cycle write and keeps sticky flags
        rd_en_i = 1'b1;
        step();
        rd_en_i = 1'b0;
        chk("t6_unf", 64'(underflow_o), 64'd1);
        for (int i = 0; i < 5; i++) push(64'h60 + 64'(i));
        chk("t6_count5", 64'(count_o), 64'd5);
        flush_i   = 1'b1;
        wr_en_i   = 1'b1;
        wr_data_i = 64'hEE;
        step();
        flush_i = 1'b0;
        wr_en_i = 1'b0;
        chk("t6_fcount", 64'(count_o), 64'd0);
        chk("t6_fempty", 64'(rd_empty_o), 64'd1);
        chk("t6_funf", 64'(underflow_o), 64'd1);
        chk("t6_fovf", 64'(overflow_o), 64'd0);
        push(64'h77);
        chk("t6_first", rd_data_o, 64'h77);
        chk("t6_count1", 64'(count_o), 64'd1);
        push(64'h78);
        push(64'h79);

        // Asynchronous reset mid-cycle clears state at once
        #3;
        axi_resetn = 1'b0;
        #1;
        chk_reset_vals("arst");
        step();
        axi_resetn = 1'b1;
        step();
        push(64'hC3);
        chk("t6_post_data", rd_data_o, 64'hC3);
        chk("t6_post_count", 64'(count_o), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
